// File: rtl/obi_cache_master.sv
// OBI master front-end for a key/value cache: turns local GET/PUT commands into
// single outstanding OBI transactions with a bounded response wait.
module obi_cache_master #(
    parameter int unsigned ARCHITECTURE   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_write_i,
    input  logic [ARCHITECTURE-1:0]     cmd_key_i,
    input  logic [2*ARCHITECTURE-1:0]   cmd_wdata_i,
    output logic                        obi_req_o,
    output logic                        obi_we_o,
    output logic [ARCHITECTURE-1:0]     obi_addr_o,
    output logic [2*ARCHITECTURE-1:0]   obi_wdata_o,
    input  logic                        obi_gnt_i,
    input  logic                        obi_rvalid_i,
    input  logic [2*ARCHITECTURE-1:0]   obi_rdata_i,
    input  logic                        obi_err_i,
    output logic                        obi_rready_o,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [2*ARCHITECTURE-1:0]   rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        rsp_timeout_o
);

    localparam int unsigned KEY_WIDTH   = ARCHITECTURE;
    localparam int unsigned VALUE_WIDTH = 2 * ARCHITECTURE;
    localparam int unsigned CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN       = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] RSP      = 2'd3;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   we_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [VALUE_WIDTH-1:0] rdata_q;
    logic                   err_q;
    logic                   timeout_q;
    logic                   timeout_hit;

    always_comb begin
        state_d     = state_q;
        timeout_hit = TO_EN && (cnt_q == CNT_LAST);
        case (state_q)
            IDLE:     if (cmd_valid_i) state_d = REQ;
            REQ:      if (obi_gnt_i) state_d = WAIT_RSP;
            WAIT_RSP: if (obi_rvalid_i || timeout_hit) state_d = RSP;
            RSP:      if (rsp_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            key_q     <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid_i) begin
                we_q    <= cmd_write_i;
                key_q   <= cmd_key_i;
                wdata_q <= cmd_wdata_i;
            end
            // Held at zero throughout REQ so the first WAIT_RSP cycle sees 0.
            if (state_q == REQ) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_RSP && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == WAIT_RSP) begin
                if (obi_rvalid_i) begin
                    rdata_q   <= we_q ? '0 : obi_rdata_i;
                    err_q     <= obi_err_i;
                    timeout_q <= 1'b0;
                end else if (timeout_hit) begin
                    rdata_q   <= '0;
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready_o   = (state_q == IDLE) && !rst;
    assign obi_req_o     = (state_q == REQ);
    assign obi_we_o      = (state_q == REQ) && we_q;
    assign obi_addr_o    = key_q;
    assign obi_wdata_o   = wdata_q;
    assign obi_rready_o  = (state_q == WAIT_RSP);
    assign rsp_valid_o   = (state_q == RSP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = timeout_q;

endmodule

// File: doc/obi_cache_master.md
OBI_CACHE_MASTER -- requirements
Module: obi_cache_master

Interface
REQ-001 Parameter ARCHITECTURE, default 64, sets the register width; key width = ARCHITECTURE, value width = 2*ARCHITECTURE.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, is the maximum response wait after grant; 0 disables the timeout.
REQ-003 The block SHALL use one clock and an asynchronous active-high reset, with ports clk and rst.
REQ-004 Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  local command present
- cmd_ready_o  out  1  block accepts command
- cmd_write_i  in  1  1 = PUT, 0 = GET
- cmd_key_i  in  KEY_WIDTH  cache key
- cmd_wdata_i  in  VALUE_WIDTH  PUT value
- obi_req_o  out  1  OBI request valid to cache interface
- obi_we_o  out  1  OBI write enable
- obi_addr_o  out  KEY_WIDTH  key on OBI address
- obi_wdata_o  out  VALUE_WIDTH  OBI write data
- obi_gnt_i  in  1  request granted by slave
- obi_rvalid_i  in  1  slave response valid
- obi_rdata_i  in  VALUE_WIDTH  slave response data
- obi_err_i  in  1  slave error flag
- obi_rready_o  out  1  master ready for response
- rsp_valid_o  out  1  local response present
- rsp_ready_i  in  1  local consumer accepts response
- rsp_rdata_o  out  VALUE_WIDTH  GET data (0 for PUT)
- rsp_err_o  out  1  slave error or timeout
- rsp_timeout_o  out  1  response missing within TIMEOUT_CYCLES

Function
REQ-005 The FSM SHALL have four states: IDLE, REQ, WAIT_RSP and RSP.
REQ-006 IDLE: cmd_ready_o=1; on cmd_valid_i the block SHALL latch write/key/wdata and go to REQ at the next edge.
REQ-007 REQ: obi_req_o=1, and obi_we_o/obi_addr_o/obi_wdata_o SHALL be driven from the latches, stable until grant.
REQ-008 REQ: obi_gnt_i=1 at an edge SHALL move the FSM to WAIT_RSP; otherwise it stays in REQ indefinitely, with no timeout.
REQ-009 WAIT_RSP: obi_rready_o=1 and obi_req_o=0; the timeout counter SHALL clear on entry and increment each cycle.
REQ-010 WAIT_RSP with obi_rvalid_i=1 at an edge: rsp_rdata_o SHALL latch obi_rdata_i for a GET or 0 for a PUT; rsp_err_o latches obi_err_i; rsp_timeout_o=0; next state RSP.
REQ-011 WAIT_RSP with counter = TIMEOUT_CYCLES-1, no rvalid and TIMEOUT_CYCLES≠0: rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; next state RSP.
REQ-012 rvalid and timeout in the same cycle: rvalid SHALL win.
REQ-013 RSP: rsp_valid_o=1 and the response outputs SHALL be stable; on rsp_ready_i go to IDLE; cmd_ready_o=0.
REQ-014 obi_rvalid_i outside WAIT_RSP SHALL be ignored, and obi_rready_o=0 there.
REQ-015 The counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and SHALL saturate, never wrapping.
REQ-016 Minimum latency (grant and rvalid each in the first eligible cycle): command accept at edge N, obi_req_o high in cycle N+1, rsp_valid_o high in cycle N+3.
REQ-017 The block SHALL hold one outstanding transaction only; no new command is accepted until the RSP handshake completes.
REQ-018 An illegal state encoding SHALL return the FSM to IDLE.

Reset
REQ-019 While rst=1, regardless of state: FSM=IDLE; obi_req_o, obi_we_o, obi_rready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; all address, data and counter registers = 0; cmd_ready_o=0 while rst is asserted, and 1 from the first cycle after release.
REQ-020 Reset mid-transaction SHALL drop obi_req_o asynchronously and discard the pending command with no local response.

Verification
REQ-021 GET, key=0x15, gnt in the first REQ cycle, rvalid with rdata=0xAB next cycle -> rsp_valid_o three cycles after accept, rsp_rdata_o=0xAB, err=0.
REQ-022 PUT, key=0x3, wdata=0x55, gnt withheld 4 cycles -> obi_req_o high 5 cycles with addr/wdata/we=1 stable; rsp_rdata_o=0.
REQ-023 GET, TIMEOUT_CYCLES=16, no rvalid -> exactly 16 WAIT_RSP cycles, then rsp_err_o=1, rsp_timeout_o=1.
REQ-024 rvalid in REQ before gnt, rvalid in IDLE -> ignored; no rsp_valid_o pulse.
REQ-025 rsp_ready_i held low 3 cycles in RSP, cmd_valid_i high -> cmd_ready_o=0 throughout; response stable; next command accepted in IDLE.
REQ-026 rst pulse during WAIT_RSP -> obi_req_o, obi_rready_o and rsp_valid_o = 0 immediately; IDLE after release.
